// File: rtl/power_pack_pkg.sv
// power_pack_pkg
// Shared encodings for the power-pack manager: pack modes, per-slot state,
// the RGB332 colour table for each mode and the shield ring constants.
// No ports; imported by power_pack_slot and power_pack_array.
// Optional feature macro used by the top level: POWER_PACK_SHIELD_EN.
package power_pack_pkg;

    typedef enum logic [1:0] {
        MODE_SHRINK = 2'd0,
        MODE_BOOST  = 2'd1,
        MODE_SPEED  = 2'd2,
        MODE_SHIELD = 2'd3
    } pack_mode_e;

    typedef enum logic [1:0] {
        SLOT_IDLE   = 2'd0,
        SLOT_SHOWN  = 2'd1,
        SLOT_ACTIVE = 2'd2
    } slot_state_e;

    // RGB332 colours, one per mode
    localparam logic [7:0] COLOUR_SHRINK = 8'b111_000_00;
    localparam logic [7:0] COLOUR_BOOST  = 8'b000_111_00;
    localparam logic [7:0] COLOUR_SPEED  = 8'b000_000_11;
    localparam logic [7:0] COLOUR_SHIELD = 8'b111_111_00;

    // Ring drawn around the paddle while a SHIELD effect is active
    localparam logic [7:0] SHIELD_RING_COLOUR = 8'b101_100_00;
    localparam int         SHIELD_BORDER      = 4;

    function automatic logic [7:0] mode_colour(input logic [1:0] mode);
        logic [7:0] colour;
        case (pack_mode_e'(mode))
            MODE_SHRINK: colour = COLOUR_SHRINK;
            MODE_BOOST:  colour = COLOUR_BOOST;
            MODE_SPEED:  colour = COLOUR_SPEED;
            default:     colour = COLOUR_SHIELD;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/power_pack_slot.sv
// power_pack_slot
// One power-pack slot: IDLE -> SHOWN -> (ACTIVE) -> IDLE state machine with a
// shared lifetime/effect frame timer, captured position and mode, and the
// combinational bounding-box hit test used by the pixel mux.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   frame_tick          one pulse per video frame, drives the timer
//   alloc               this slot was chosen for the current spawn
//   eaten               pickup pulse from collision logic
//   randx, randy        position captured on alloc
//   mode_in             rotor value captured on alloc
//   hcount, vcount      current pixel position for the hit test
//   is_idle/is_shown/is_active  decoded state
//   mode                captured mode
//   pos_x, pos_y        position, zero whenever the slot is not SHOWN
//   hit                 SHOWN and the pixel lies inside the pack box
module power_pack_slot
    import power_pack_pkg::*;
#(
    parameter int WIDTH         = 20,
    parameter int HEIGHT        = 20,
    parameter int LIFETIME      = 600,
    parameter int EFFECT_FRAMES = 300,
    parameter int TW            = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        alloc,
    input  logic        eaten,
    input  logic [10:0] randx,
    input  logic [9:0]  randy,
    input  logic [1:0]  mode_in,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic        is_idle,
    output logic        is_shown,
    output logic        is_active,
    output logic [1:0]  mode,
    output logic [10:0] pos_x,
    output logic [9:0]  pos_y,
    output logic        hit
);

    slot_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [10:0]   x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [1:0]    mode_q, mode_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SLOT_IDLE;
            timer_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        case (state_q)
            SLOT_IDLE: begin
                if (alloc) begin
                    state_d = SLOT_SHOWN;
                    timer_d = TW'(LIFETIME);
                    x_d     = randx;
                    y_d     = randy;
                    mode_d  = mode_in;
                end
            end
            SLOT_SHOWN: begin
                // A pickup on the expiring frame still counts as a pickup
                if (eaten) begin
                    state_d = SLOT_ACTIVE;
                    timer_d = TW'(EFFECT_FRAMES);
                    x_d     = '0;
                    y_d     = '0;
                end else if (frame_tick) begin
                    if (timer_q == TW'(1)) begin
                        state_d = SLOT_IDLE;
                        timer_d = '0;
                        x_d     = '0;
                        y_d     = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            SLOT_ACTIVE: begin
                if (frame_tick) begin
                    if (timer_q == TW'(1)) begin
                        state_d = SLOT_IDLE;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q - TW'(1);
                    end
                end
            end
            default: begin
                state_d = SLOT_IDLE;
                timer_d = '0;
                x_d     = '0;
                y_d     = '0;
            end
        endcase
    end

    // Box edges are widened by one bit so packs near the right/bottom edge
    // never wrap around to the left/top of the screen.
    logic [11:0] x_end;
    logic [10:0] y_end;

    assign x_end = {1'b0, x_q} + 12'(WIDTH);
    assign y_end = {1'b0, y_q} + 11'(HEIGHT);

    assign is_idle   = (state_q == SLOT_IDLE);
    assign is_shown  = (state_q == SLOT_SHOWN);
    assign is_active = (state_q == SLOT_ACTIVE);
    assign mode      = mode_q;
    assign pos_x     = is_shown ? x_q : 11'd0;
    assign pos_y     = is_shown ? y_q : 10'd0;

    assign hit = is_shown
              && (hcount >= x_q) && ({1'b0, hcount} < x_end)
              && (vcount >= y_q) && ({1'b0, vcount} < y_end);

endmodule

// File: rtl/power_pack_array.sv
// power_pack_array
// Multi-slot power-up manager for the Pong datapath. Spawns packs into the
// lowest free slot, rotates the mode assigned to each new pack, reports slot
// positions for collision, ORs active effects into active_modes and drives a
// registered RGB332 overlay pixel (lowest slot wins on overlap).
// Optional feature macro: POWER_PACK_SHIELD_EN -- when defined, a border ring
// is drawn around the paddle while a SHIELD effect is active; when undefined,
// the paddle ports are accepted but ignored.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   frame_tick                 one pulse per video frame
//   spawn                      request a new pack
//   eaten[NUM_PACKS]           per-slot pickup pulse
//   hcount, vcount             current VGA pixel
//   randx, randy               candidate spawn position
//   paddle_x/y/w/h             paddle rectangle for the shield ring
//   pack_x, pack_y             packed per-slot positions (0 when not SHOWN)
//   shown                      per-slot SHOWN flag
//   active_modes               bit m set while any slot has effect m active
//   rand_req                   pulse after an accepted spawn
//   spawn_drop                 pulse after a spawn with no free slot
//   pixel                      registered overlay colour (1-cycle latency)
module power_pack_array
    import power_pack_pkg::*;
#(
    parameter int NUM_PACKS     = 4,
    parameter int WIDTH         = 20,
    parameter int HEIGHT        = 20,
    parameter int LIFETIME      = 600,
    parameter int EFFECT_FRAMES = 300,
    parameter int TW            = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_tick,
    input  logic                    spawn,
    input  logic [NUM_PACKS-1:0]    eaten,
    input  logic [10:0]             hcount,
    input  logic [9:0]              vcount,
    input  logic [10:0]             randx,
    input  logic [9:0]              randy,
    input  logic [10:0]             paddle_x,
    input  logic [9:0]              paddle_y,
    input  logic [9:0]              paddle_w,
    input  logic [9:0]              paddle_h,
    output logic [NUM_PACKS*11-1:0] pack_x,
    output logic [NUM_PACKS*10-1:0] pack_y,
    output logic [NUM_PACKS-1:0]    shown,
    output logic [3:0]              active_modes,
    output logic                    rand_req,
    output logic                    spawn_drop,
    output logic [7:0]              pixel
);

    logic [NUM_PACKS-1:0] idle_v;
    logic [NUM_PACKS-1:0] active_v;
    logic [NUM_PACKS-1:0] hit_v;
    logic [NUM_PACKS-1:0] grant_v;
    logic [NUM_PACKS-1:0] alloc_v;
    logic [1:0]           mode_v [NUM_PACKS];
    logic [10:0]          x_v    [NUM_PACKS];
    logic [9:0]           y_v    [NUM_PACKS];

    logic [1:0] rotor_q, rotor_d;
    logic       rand_req_q, rand_req_d;
    logic       spawn_drop_q, spawn_drop_d;
    logic [7:0] pixel_q, pixel_d;
    logic       any_idle;
    logic       accept;

    for (genvar g = 0; g < NUM_PACKS; g++) begin : g_slot
        power_pack_slot #(
            .WIDTH         (WIDTH),
            .HEIGHT        (HEIGHT),
            .LIFETIME      (LIFETIME),
            .EFFECT_FRAMES (EFFECT_FRAMES),
            .TW            (TW)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .frame_tick (frame_tick),
            .alloc      (alloc_v[g]),
            .eaten      (eaten[g]),
            .randx      (randx),
            .randy      (randy),
            .mode_in    (rotor_q),
            .hcount     (hcount),
            .vcount     (vcount),
            .is_idle    (idle_v[g]),
            .is_shown   (shown[g]),
            .is_active  (active_v[g]),
            .mode       (mode_v[g]),
            .pos_x      (x_v[g]),
            .pos_y      (y_v[g]),
            .hit        (hit_v[g])
        );

        assign pack_x[g*11 +: 11] = x_v[g];
        assign pack_y[g*10 +: 10] = y_v[g];
    end

    // Lowest-index IDLE slot takes the spawn; at most one grant per cycle
    always_comb begin
        logic found;
        grant_v = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_PACKS; i++) begin
            if (!found && idle_v[i]) begin
                grant_v[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_idle = |idle_v;
    assign accept   = spawn && any_idle;
    assign alloc_v  = spawn ? grant_v : '0;

    always_comb begin
        rotor_d      = accept ? rotor_q + 2'd1 : rotor_q;
        rand_req_d   = accept;
        spawn_drop_d = spawn && !any_idle;
    end

    always_comb begin
        active_modes = 4'b0000;
        for (int i = 0; i < NUM_PACKS; i++) begin
            if (active_v[i]) begin
                active_modes[mode_v[i]] = 1'b1;
            end
        end
    end

`ifdef POWER_PACK_SHIELD_EN
    // Ring = outer rectangle grown by SHIELD_BORDER on every side, minus the
    // paddle itself. The left/top test is written as h+B >= x to avoid
    // underflow when the paddle touches the screen edge.
    logic [11:0] h_ext, v_ext, px_lo, px_hi, py_lo, py_hi;
    logic        in_outer, in_inner, ring_hit;

    assign h_ext = {1'b0, hcount};
    assign v_ext = {2'b00, vcount};
    assign px_lo = {1'b0, paddle_x};
    assign px_hi = px_lo + {2'b00, paddle_w};
    assign py_lo = {2'b00, paddle_y};
    assign py_hi = py_lo + {2'b00, paddle_h};

    assign in_outer = (h_ext + 12'(SHIELD_BORDER) >= px_lo)
                   && (h_ext < px_hi + 12'(SHIELD_BORDER))
                   && (v_ext + 12'(SHIELD_BORDER) >= py_lo)
                   && (v_ext < py_hi + 12'(SHIELD_BORDER));
    assign in_inner = (h_ext >= px_lo) && (h_ext < px_hi)
                   && (v_ext >= py_lo) && (v_ext < py_hi);
    assign ring_hit = active_modes[MODE_SHIELD] && in_outer && !in_inner;
`else
    logic unused_paddle;
    assign unused_paddle = ^{paddle_x, paddle_y, paddle_w, paddle_h};
`endif

    // Walk from the highest slot down so the lowest hitting slot is applied last
    always_comb begin
        pixel_d = 8'h00;
`ifdef POWER_PACK_SHIELD_EN
        if (ring_hit) begin
            pixel_d = SHIELD_RING_COLOUR;
        end
`endif
        for (int i = NUM_PACKS - 1; i >= 0; i--) begin
            if (hit_v[i]) begin
                pixel_d = mode_colour(mode_v[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rotor_q      <= '0;
            rand_req_q   <= 1'b0;
            spawn_drop_q <= 1'b0;
            pixel_q      <= '0;
        end else begin
            rotor_q      <= rotor_d;
            rand_req_q   <= rand_req_d;
            spawn_drop_q <= spawn_drop_d;
            pixel_q      <= pixel_d;
        end
    end

    assign rand_req   = rand_req_q;
    assign spawn_drop = spawn_drop_q;
    assign pixel      = pixel_q;

endmodule

// File: tb/tb_power_pack_array.sv
// tb_power_pack_array
// Scoreboard bench for power_pack_array: a driver applies directed and random
// stimulus on the falling edge, a slot-level reference model predicts every
// output for the following rising edge and queues it, and a monitor pops and
// compares after each rising edge.
module tb_power_pack_array;

    localparam int N    = 4;
    localparam int W    = 20;
    localparam int H    = 20;
    localparam int LIFE = 3;
    localparam int EFX  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset = 1'b1;
    logic              frame_tick = 1'b0;
    logic              spawn = 1'b0;
    logic [N-1:0]      eaten = '0;
    logic [10:0]       hcount = '0;
    logic [9:0]        vcount = '0;
    logic [10:0]       randx = '0;
    logic [9:0]        randy = '0;
    logic [10:0]       paddle_x = 11'd600;
    logic [9:0]        paddle_y = 10'd300;
    logic [9:0]        paddle_w = 10'd80;
    logic [9:0]        paddle_h = 10'd10;
    logic [N*11-1:0]   pack_x;
    logic [N*10-1:0]   pack_y;
    logic [N-1:0]      shown;
    logic [3:0]        active_modes;
    logic              rand_req;
    logic              spawn_drop;
    logic [7:0]        pixel;

    power_pack_array #(
        .NUM_PACKS     (N),
        .WIDTH         (W),
        .HEIGHT        (H),
        .LIFETIME      (LIFE),
        .EFFECT_FRAMES (EFX),
        .TW            (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .spawn        (spawn),
        .eaten        (eaten),
        .hcount       (hcount),
        .vcount       (vcount),
        .randx        (randx),
        .randy        (randy),
        .paddle_x     (paddle_x),
        .paddle_y     (paddle_y),
        .paddle_w     (paddle_w),
        .paddle_h     (paddle_h),
        .pack_x       (pack_x),
        .pack_y       (pack_y),
        .shown        (shown),
        .active_modes (active_modes),
        .rand_req     (rand_req),
        .spawn_drop   (spawn_drop),
        .pixel        (pixel)
    );

    typedef struct {
        logic [N-1:0]    shown;
        logic [N*11-1:0] px;
        logic [N*10-1:0] py;
        logic [3:0]      am;
        logic            rr;
        logic            sd;
        logic [7:0]      pix;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: 0 = idle, 1 = on screen, 2 = effect running
    int m_st   [N];
    int m_x    [N];
    int m_y    [N];
    int m_mode [N];
    int m_left [N];
    int m_rotor;

    function automatic logic [7:0] colour_of(input int m);
        case (m)
            0:       return 8'hE0;
            1:       return 8'h1C;
            2:       return 8'h03;
            default: return 8'hFC;
        endcase
    endfunction

    task automatic model_step();
        exp_t e;
        int   hc, vc, free_slot;
        logic shield_on;
        hc = int'(hcount);
        vc = int'(vcount);
        e.pix = 8'h00;

        // Pixel is computed from what was on screen before this edge
        shield_on = 1'b0;
        for (int i = 0; i < N; i++)
            if (m_st[i] == 2 && m_mode[i] == 3) shield_on = 1'b1;
`ifdef POWER_PACK_SHIELD_EN
        begin
            int ax, ay, aw, ah;
            ax = int'(paddle_x); ay = int'(paddle_y);
            aw = int'(paddle_w); ah = int'(paddle_h);
            if (shield_on && hc >= ax - 4 && hc < ax + aw + 4 && vc >= ay - 4 && vc < ay + ah + 4
                && !(hc >= ax && hc < ax + aw && vc >= ay && vc < ay + ah))
                e.pix = 8'b101_100_00;
        end
`endif
        begin
            int winner;
            winner = -1;
            for (int i = 0; i < N; i++)
                if (winner < 0 && m_st[i] == 1 && hc >= m_x[i] && hc < m_x[i] + W
                    && vc >= m_y[i] && vc < m_y[i] + H)
                    winner = i;
            if (winner >= 0) e.pix = colour_of(m_mode[winner]);
        end

        e.rr = 1'b0;
        e.sd = 1'b0;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_mode[i] = 0; m_left[i] = 0;
            end
            m_rotor = 0;
            e.pix   = 8'h00;
        end else begin
            free_slot = -1;
            if (spawn)
                for (int i = N - 1; i >= 0; i--)
                    if (m_st[i] == 0) free_slot = i;
            for (int i = 0; i < N; i++) begin
                if (m_st[i] == 1 && eaten[i]) begin
                    m_st[i] = 2;
                    m_left[i] = EFX;
                end else if (m_st[i] != 0 && frame_tick) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) m_st[i] = 0;
                end
            end
            if (free_slot >= 0) begin
                m_st[free_slot]   = 1;
                m_x[free_slot]    = int'(randx);
                m_y[free_slot]    = int'(randy);
                m_mode[free_slot] = m_rotor;
                m_left[free_slot] = LIFE;
                m_rotor           = (m_rotor + 1) % 4;
                e.rr = 1'b1;
            end else if (spawn) begin
                e.sd = 1'b1;
            end
        end

        e.am = 4'b0000;
        for (int i = 0; i < N; i++) begin
            e.shown[i]        = (m_st[i] == 1);
            e.px[i*11 +: 11]  = (m_st[i] == 1) ? 11'(m_x[i]) : 11'd0;
            e.py[i*10 +: 10]  = (m_st[i] == 1) ? 10'(m_y[i]) : 10'd0;
            if (m_st[i] == 2) e.am[m_mode[i]] = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: one expected record per rising edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("shown",        64'(shown),        64'(e.shown));
                check("pack_x",       64'(pack_x),       64'(e.px));
                check("pack_y",       64'(pack_y),       64'(e.py));
                check("active_modes", 64'(active_modes), 64'(e.am));
                check("rand_req",     64'(rand_req),     64'(e.rr));
                check("spawn_drop",   64'(spawn_drop),   64'(e.sd));
                check("pixel",        64'(pixel),        64'(e.pix));
            end
        end
    end

    task automatic step(input logic r, input logic sp, input logic tk, input logic [N-1:0] ea,
                        input int rx, input int ry, input int hc, input int vc);
        @(negedge clk);
        reset      = r;
        spawn      = sp;
        frame_tick = tk;
        eaten      = ea;
        randx      = 11'(rx);
        randy      = 10'(ry);
        hcount     = 11'(hc);
        vcount     = 10'(vc);
        model_step();
    endtask

    initial begin
        // Reset
        for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 1'b0, '0, 0, 0, 0, 0);
        // First spawn lands in slot 0, then fill the rest; the fifth is dropped
        step(1'b0, 1'b1, 1'b0, '0, 700, 500, 0, 0);
        step(1'b0, 1'b1, 1'b0, '0, 100, 40, 0, 0);
        step(1'b0, 1'b1, 1'b0, '0, 100, 40, 0, 0);
        step(1'b0, 1'b1, 1'b0, '0, 1270, 1000, 0, 0);
        step(1'b0, 1'b1, 1'b0, '0, 300, 300, 0, 0);
        step(1'b0, 1'b0, 1'b0, '0, 0, 0, 0, 0);
        // Overlap of slots 1 and 2, right-edge pack and no wrap near x=0
        for (int h = 96; h < 124; h++) step(1'b0, 1'b0, 1'b0, '0, 0, 0, h, 45);
        for (int h = 1266; h < 1295; h++) step(1'b0, 1'b0, 1'b0, '0, 0, 0, h, 1010);
        for (int h = 0; h < 12; h++) step(1'b0, 1'b0, 1'b0, '0, 0, 0, h, 1010);
        // Pick up the SHIELD pack in slot 3 and scan around the paddle
        step(1'b0, 1'b0, 1'b0, 4'b1000, 0, 0, 0, 0);
        for (int h = 592; h < 690; h += 3) step(1'b0, 1'b0, 1'b0, '0, 0, 0, h, 298);
        step(1'b0, 1'b0, 1'b0, '0, 0, 0, 596, 305);
        step(1'b0, 1'b0, 1'b0, '0, 0, 0, 595, 305);
        step(1'b0, 1'b0, 1'b0, '0, 0, 0, 640, 305);
        // Two ticks end the effect; the third coincides with eaten[0]
        step(1'b0, 1'b0, 1'b1, '0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b1, '0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b1, 4'b0001, 0, 0, 705, 505);
        for (int h = 96; h < 124; h += 4) step(1'b0, 1'b0, 1'b0, '0, 0, 0, h, 45);
        step(1'b0, 1'b0, 1'b1, '0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 1'b1, '0, 0, 0, 0, 0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int rx, ry, hc, vc, k;
            logic [N-1:0] ea;
            case ($urandom_range(0, 4))
                0:       begin rx = 700;  ry = 500;  end
                1:       begin rx = 100;  ry = 40;   end
                2:       begin rx = 1270; ry = 1010; end
                3:       begin rx = 105;  ry = 50;   end
                default: begin rx = int'($urandom_range(0, 2047)); ry = int'($urandom_range(0, 1023)); end
            endcase
            case ($urandom_range(0, 3))
                0, 1: begin
                    k  = int'($urandom_range(0, N - 1));
                    hc = m_x[k] + int'($urandom_range(0, W + 3)) - 2;
                    vc = m_y[k] + int'($urandom_range(0, H + 3)) - 2;
                end
                2: begin
                    hc = int'($urandom_range(0, 15));
                    vc = int'($urandom_range(0, 15));
                end
                default: begin
                    hc = 594 + int'($urandom_range(0, 92));
                    vc = 294 + int'($urandom_range(0, 22));
                end
            endcase
            if (hc < 0) hc = 0;
            if (hc > 2047) hc = 2047;
            if (vc < 0) vc = 0;
            if (vc > 1023) vc = 1023;
            for (int b = 0; b < N; b++) ea[b] = ($urandom_range(0, 5) == 0);
            step($urandom_range(0, 599) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0, ea, rx, ry, hc, vc);
        end

        @(posedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/power_pack_array.md
# power_pack_array

Multi-slot power-up manager for the Pong datapath: holds up to `NUM_PACKS` on-screen power packs, each with its own mode, position, on-screen lifetime and post-pickup effect timer. It sits between the random-position generator, the ball/paddle collision logic and the VGA pixel mux. It spawns packs into free slots and reports pack positions for collision checks. It exposes which effects are currently active and produces a registered pixel colour for the pack overlay.

## Interface
Parameters:
- `NUM_PACKS`, 4: number of independent slots (1..8).
- `WIDTH`, 20: pack width in pixels.
- `HEIGHT`, 20: pack height in pixels.
- `LIFETIME`, 600: frames a pack stays displayed if not eaten (≥1).
- `EFFECT_FRAMES`, 300: frames an effect stays active after pickup (≥1).
- `TW`, 10: width of the lifetime/effect frame counters.

Ports:
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per video frame; all timers count on it.
- `spawn` in 1: request to place a new pack; sampled every cycle.
- `eaten` in `NUM_PACKS`: per-slot pickup pulse from collision logic.
- `hcount` in 11 / `vcount` in 10: current VGA pixel position.
- `randx` in 11 / `randy` in 10: candidate position from the random generator.
- `paddle_x` in 11 / `paddle_y` in 10 / `paddle_w` in 10 / `paddle_h` in 10: paddle geometry for the shield ring.
- `pack_x` out `NUM_PACKS*11`: per-slot x position, slot i at `[i*11 +: 11]`; 0 when the slot is not SHOWN.
- `pack_y` out `NUM_PACKS*10`: per-slot y position, same packing and rule.
- `shown` out `NUM_PACKS`: slot is SHOWN and collidable.
- `active_modes` out 4: bit m set while any slot is ACTIVE with mode m.
- `rand_req` out 1: one-cycle pulse asking the generator for a new position.
- `spawn_drop` out 1: one-cycle pulse when a spawn finds no free slot.
- `pixel` out 8: RGB332 overlay colour, registered.

## Operation
- Per-slot state: IDLE, SHOWN, ACTIVE. Reset puts every slot in IDLE with timers, positions and the mode rotor cleared.
- Mode rotor: a 2-bit counter that advances on each accepted spawn. Mode order is SHRINK=0, BOOST=1, SPEED=2, SHIELD=3.
- IDLE→SHOWN on `spawn` when the slot is the lowest-index IDLE slot. On that transition the slot:
  - captures `randx`/`randy` and the current rotor value as its mode;
  - loads its life timer with `LIFETIME`.
- If `spawn` arrives and no slot is IDLE, the spawn is dropped and `spawn_drop` pulses. The rotor does not advance.
- SHOWN behaviour:
  - `eaten[i]` moves the slot to ACTIVE and loads the timer with `EFFECT_FRAMES`. `pack_x`/`pack_y` are cleared to 0.
  - Otherwise, on each `frame_tick` the timer decrements. When the timer is 1 and a tick arrives, the slot goes to IDLE.
- ACTIVE: on each `frame_tick` the timer decrements. It reaches IDLE on the tick at which the timer is 1.
- `eaten[i]` is ignored in IDLE and in ACTIVE.
- Same-cycle `eaten[i]` and expiry tick: eaten wins.
- Only one slot is allocated per `spawn` cycle.
- Pixel: a slot draws when SHOWN and `x ≤ hcount < x+WIDTH` and `y ≤ vcount < y+HEIGHT`.
  - Sums are computed at 12/11 bits, so there is no wrap at the screen edge.
  - On overlap, the lowest-index slot wins.
  - Colour comes from a per-mode table.

## Timing
- All state updates occur on the rising edge of `clk`.
- `shown`, `pack_x` and `pack_y` are valid the cycle after an accepted `spawn`.
- `rand_req` pulses in that same cycle, so the generator has a full frame to produce the next candidate.
- `active_modes` updates the cycle after `eaten`. It clears the cycle after the final tick.
- `pixel` has 1-cycle latency from `hcount`/`vcount`. The VGA mux delays its sync signals by one cycle to match.
- `reset` mid-operation returns all outputs to 0 on the next edge. There is no drain of active effects.

## Configuration
- Macro: `POWER_PACK_SHIELD_EN`.
- With it defined: while `active_modes[3]` is set, `pixel` also draws a 4-pixel border ring around the paddle rectangle in colour 8'b101_100_00. Pack pixels take priority over the ring.
- Without it: the paddle ports are present but unused, and no ring is drawn. SHIELD still appears in `active_modes[3]`.

## Structure
- `power_pack_pkg` holds:
  - the mode encodings (SHRINK/BOOST/SPEED/SHIELD);
  - the slot state encoding (IDLE/SHOWN/ACTIVE);
  - the per-mode RGB332 colour constants;
  - the shield colour and border width.
- Sub-module `power_pack_slot` is one slot and is instantiated `NUM_PACKS` times. It contains the FSM, timer, position/mode registers and the hit test.
- The top level contains the free-slot priority encoder, the mode rotor, the `active_modes` OR-reduction and the pixel priority mux.

## Test plan
- Reset, then `spawn` with randx=700, randy=500: slot0 becomes SHOWN, `pack_x[10:0]`=700, mode=SHRINK, `rand_req` pulses once.
- Four spawns: slots 0..3 SHOWN with modes 0,1,2,3. A fifth spawn pulses `spawn_drop` and the rotor stays at 0.
- With LIFETIME=3, spawn and then apply 3 `frame_tick`s: the slot returns to IDLE after the third tick. `pack_x`=0 and the pixel is blank over the old area.
- SHOWN slot3 (SHIELD) gets `eaten[3]`: `active_modes`=4'b1000 next cycle. With EFFECT_FRAMES=2, it clears after 2 ticks. With the macro defined, the ring appears at `hcount`=paddle_x-4.
- `eaten[0]` coincident with the expiring tick: slot0 goes to ACTIVE, not IDLE.
- Overlapping slots 0 and 1 at the same position: `pixel` shows the slot0 colour one cycle after `hcount` enters the box. Also check that x=1270, WIDTH=20 draws to hcount 1289 without wrap.
